combo_score_controller: RTL and testbench

COMBO_SCORE_CONTROLLER -- requirements
Module: combo_score_controller

---
 rtl/combo_score_controller.sv | 154 +++++++++++++++
 tb/tb_combo_score_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/combo_score_controller.sv
// Whack-a-mole game controller: countdown/play/over sequencing, hit combo tracking,
// and a valid/ready score-add request with saturating accumulation of deferred points.
module combo_score_controller #(
  parameter int MAX_COMBO       = 99,
  parameter int ROUND_TICKS     = 60,
  parameter int COUNTDOWN_TICKS = 3,
  localparam int TW = $clog2(((ROUND_TICKS > COUNTDOWN_TICKS) ? ROUND_TICKS
                                                             : COUNTDOWN_TICKS) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tick,
  input  logic          hit,
  input  logic          miss,
  input  logic          add_ready,
  output logic          add_valid,
  output logic [4:0]    add_amount,
  output logic          score_clr,
  output logic [6:0]    combo_count,
  output logic [TW-1:0] time_left,
  output logic [1:0]    state,
  output logic          game_over
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } state_e;

  localparam logic [6:0]    MAX_C   = 7'(MAX_COMBO);
  localparam logic [TW-1:0] CD_T    = TW'(COUNTDOWN_TICKS);
  localparam logic [TW-1:0] ROUND_T = TW'(ROUND_TICKS);
  localparam logic [TW-1:0] ONE_T   = TW'(1);

  state_e          state_q, state_d;
  logic [TW-1:0]   time_q, time_d;
  logic [6:0]      combo_q, combo_d;
  logic            add_valid_q, add_valid_d;
  logic [4:0]      add_amount_q, add_amount_d;
  logic [4:0]      pending_q, pending_d;
  logic            score_clr_q, score_clr_d;
  logic            game_over_q, game_over_d;

  logic            hit_play, miss_play;
  logic [6:0]      combo_inc;
  logic [4:0]      pts;
  logic [5:0]      sum;
  logic [4:0]      sum_sat;

  // A hit on the final PLAY tick still sees state_q == PLAY, so it counts naturally.
  assign hit_play  = (state_q == PLAY) && hit && !miss;
  assign miss_play = (state_q == PLAY) && miss;
  assign combo_inc = (combo_q >= MAX_C) ? MAX_C : combo_q + 7'd1;
  assign pts       = hit_play ? 5'(7'd1 + combo_inc / 7'd10) : 5'd0;
  assign sum       = {1'b0, pending_q} + {1'b0, pts};
  assign sum_sat   = sum[5] ? 5'd31 : sum[4:0];

  // NOTE: every _d gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    combo_d      = combo_q;
    add_valid_d  = add_valid_q;
    add_amount_d = add_amount_q;
    pending_d    = pending_q;
    score_clr_d  = 1'b0;

    if (miss_play)     combo_d = 7'd0;
    else if (hit_play) combo_d = combo_inc;

    if (add_valid_q && add_ready) begin
      pending_d    = 5'd0;
      add_valid_d  = (sum_sat != 5'd0);
      add_amount_d = sum_sat;
    end else if (add_valid_q) begin
      pending_d = sum_sat;
    end else if (pts != 5'd0) begin
      add_valid_d  = 1'b1;
      add_amount_d = pts;
    end

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d      = COUNTDOWN;
          time_d       = CD_T;
          combo_d      = 7'd0;
          score_clr_d  = 1'b1;
          pending_d    = 5'd0;
          add_valid_d  = 1'b0;
          add_amount_d = 5'd0;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (time_q == ONE_T) begin
            state_d = PLAY;
            time_d  = ROUND_T;
          end else begin
            time_d = time_q - ONE_T;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (time_q == ONE_T) begin
            state_d = OVER;
            time_d  = '0;
          end else begin
            time_d = time_q - ONE_T;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      time_q       <= '0;
      combo_q      <= 7'd0;
      add_valid_q  <= 1'b0;
      add_amount_q <= 5'd0;
      pending_q    <= 5'd0;
      score_clr_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      combo_q      <= combo_d;
      add_valid_q  <= add_valid_d;
      add_amount_q <= add_amount_d;
      pending_q    <= pending_d;
      score_clr_q  <= score_clr_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state       = state_q;
  assign time_left   = time_q;
  assign combo_count = combo_q;
  assign add_valid   = add_valid_q;
  assign add_amount  = add_amount_q;
  assign score_clr   = score_clr_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_combo_score_controller.sv
// Directed bench for combo_score_controller; accepted add transfers are checked
// against a queue of expected amounts filled as hits are driven.
module tb_combo_score_controller;

  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst, start, tick, hit, miss, add_ready;
  logic          add_valid, score_clr, game_over;
  logic [4:0]    add_amount;
  logic [6:0]    combo_count;
  logic [TW-1:0] time_left;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int combo_m = 0;

  combo_score_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .tick        (tick),
    .hit         (hit),
    .miss        (miss),
    .add_ready   (add_ready),
    .add_valid   (add_valid),
    .add_amount  (add_amount),
    .score_clr   (score_clr),
    .combo_count (combo_count),
    .time_left   (time_left),
    .state       (state),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives n back-to-back hits; optionally queues the points each one should produce.
  task automatic hits(input int n, input bit push);
    hit = 1'b1;
    for (int i = 0; i < n; i++) begin
      combo_m = (combo_m >= 99) ? 99 : combo_m + 1;
      if (push) sb_q.push_back(1 + combo_m / 10);
      cycle();
    end
    hit = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_time"}, time_left, 0);
    check({tag, "_combo"}, combo_count, 0);
    check({tag, "_valid"}, add_valid, 0);
    check({tag, "_amount"}, add_amount, 0);
    check({tag, "_clr"}, score_clr, 0);
    check({tag, "_over"}, game_over, 0);
  endtask

  // Scoreboard: compare each accepted transfer against the oldest expected amount.
  always @(negedge clk) begin
    if (rst === 1'b0 && add_valid === 1'b1 && add_ready === 1'b1) begin
      checks++;
      assert (sb_q.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_unexpected observed amount=%0d expected no transfer", add_amount);
      end
      if (sb_q.size() > 0) check("sb_amount", add_amount, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; hit = 1'b0; miss = 1'b0; add_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    check_reset_vals("reset");

    // tick ignored in IDLE
    tick = 1'b1; cycle(); tick = 1'b0;
    check("idle_tick_state", state, 0);
    check("idle_tick_time", time_left, 0);

    // start flow
    start = 1'b1; cycle(); start = 1'b0;
    check("start_clr", score_clr, 1);
    check("start_state", state, 1);
    check("start_time", time_left, 3);
    check("start_combo", combo_count, 0);
    hit = 1'b1; cycle(); hit = 1'b0;
    check("cd_clr_drop", score_clr, 0);
    check("cd_hit_combo", combo_count, 0);
    check("cd_hit_valid", add_valid, 0);
    tick = 1'b1; start = 1'b1; cycle(); start = 1'b0;
    check("cd_tick1_time", time_left, 2);
    check("cd_start_ignored_state", state, 1);
    check("cd_start_ignored_clr", score_clr, 0);
    cycle();
    check("cd_tick2_time", time_left, 1);
    cycle(); tick = 1'b0;
    check("play_state", state, 2);
    check("play_time", time_left, 60);

    // combo points with ready held high
    add_ready = 1'b1;
    hits(12, 1'b1);
    check("combo12", combo_count, 12);
    check("combo12_amount", add_amount, 2);
    cycle();
    check("combo12_drained", add_valid, 0);
    check("combo12_sb_empty", sb_q.size(), 0);

    // backpressure
    miss = 1'b1; cycle(); miss = 1'b0; combo_m = 0;
    check("miss_combo", combo_count, 0);
    check("miss_valid", add_valid, 0);
    hits(8, 1'b1);
    cycle();
    check("bp_combo8", combo_count, 8);
    check("bp_idle_valid", add_valid, 0);
    add_ready = 1'b0;
    hits(1, 1'b0);
    check("bp_first_valid", add_valid, 1);
    check("bp_first_amount", add_amount, 1);
    for (int i = 0; i < 2; i++) begin
      hits(1, 1'b0);
      check("bp_hold_valid", add_valid, 1);
      check("bp_hold_amount", add_amount, 1);
    end
    check("bp_combo11", combo_count, 11);
    sb_q.push_back(1);
    sb_q.push_back(4);
    add_ready = 1'b1;
    cycle();
    check("bp_pending_valid", add_valid, 1);
    check("bp_pending_amount", add_amount, 4);
    cycle();
    check("bp_after_valid", add_valid, 0);
    check("bp_after_amount", add_amount, 0);

    // saturation, then hit+miss conflict
    hits(120, 1'b1);
    check("sat_combo", combo_count, 99);
    check("sat_amount", add_amount, 10);
    hit = 1'b1; miss = 1'b1; cycle(); hit = 1'b0; miss = 1'b0; combo_m = 0;
    check("conflict_combo", combo_count, 0);
    check("conflict_valid", add_valid, 0);
    cycle();
    check("conflict_no_req", add_valid, 0);

    // round end with coincident hit
    check("round_time_full", time_left, 60);
    tick = 1'b1;
    repeat (59) cycle();
    tick = 1'b0;
    check("round_last_time", time_left, 1);
    check("round_last_state", state, 2);
    tick = 1'b1; hits(1, 1'b1); tick = 1'b0;
    check("over_state", state, 3);
    check("over_flag", game_over, 1);
    check("over_time", time_left, 0);
    check("over_combo", combo_count, 1);
    check("over_drain_valid", add_valid, 1);
    check("over_drain_amount", add_amount, 1);
    cycle();
    check("over_drained", add_valid, 0);
    hit = 1'b1; cycle(); hit = 1'b0;
    check("over_hit_combo", combo_count, 1);
    check("over_hit_valid", add_valid, 0);
    tick = 1'b1; cycle(); tick = 1'b0;
    check("over_tick_time", time_left, 0);
    check("over_tick_state", state, 3);
    start = 1'b1; cycle(); start = 1'b0;
    check("restart_clr", score_clr, 1);
    check("restart_state", state, 1);
    check("restart_time", time_left, 3);
    check("restart_combo", combo_count, 0);
    check("restart_over", game_over, 0);
    cycle();
    check("restart_clr_drop", score_clr, 0);

    // mid-game reset with request outstanding and points pending
    tick = 1'b1; repeat (3) cycle(); tick = 1'b0;
    check("rst_play_state", state, 2);
    add_ready = 1'b0; combo_m = 0;
    hits(2, 1'b0);
    check("rst_pre_valid", add_valid, 1);
    check("rst_pre_combo", combo_count, 2);
    rst = 1'b1; hit = 1'b1; start = 1'b1; cycle();
    rst = 1'b0; hit = 1'b0; start = 1'b0;
    check_reset_vals("midrst");
    add_ready = 1'b1; cycle();
    check("midrst_no_drain", add_valid, 0);
    check("midrst_idle", state, 0);

    check("sb_final_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
